// File: rtl/mult_unit_32_pkg.sv
// Shared constants and state encoding for the MULT/MULTU multiplier.
package mult_unit_32_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned Iter         = 32;
  localparam int unsigned CntWidth     = $clog2(Iter);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFin  = 2'd2
  } state_e;

endpackage

// File: rtl/mult_unit_32_if.sv
// Request/result bundle between the datapath and the multiplier.
interface mult_unit_32_if
  import mult_unit_32_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/adder_32_bit.sv
// Ripple-style word adder with carry in/out, shared by accumulate and negate steps.
module adder_32_bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cin_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o
);

  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/mult_unit_32.sv
// Multi-cycle shift-add multiplier feeding HI/LO; one partial product per clock,
// sign-magnitude handling for MULT with a final two-word negate.
module mult_unit_32
  import mult_unit_32_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input logic           clk,
  input logic           reset,
  mult_unit_32_if.slave bus
);

  state_e               state_q, state_d;
  logic [CntWidth-1:0]  cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [WIDTH-1:0]     ma_q, ma_d;
  logic                 sign_q, sign_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic [WIDTH-1:0]     abs_a, abs_b;
  logic [WIDTH-1:0]     add_a, add_b, add_sum;
  logic                 add_cin, add_cout;
  logic [WIDTH-1:0]     neg_hi;
  logic                 unused_neg_cout;

  // Magnitudes; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
  always_comb begin
    abs_a = bus.a;
    abs_b = bus.b;
    if (bus.is_signed && bus.a[WIDTH-1]) abs_a = ~bus.a + WIDTH'(1);
    if (bus.is_signed && bus.b[WIDTH-1]) abs_b = ~bus.b + WIDTH'(1);
  end

  // In FIN the accumulate adder becomes the low half of ~P + 1.
  always_comb begin
    add_a   = p_q[2*WIDTH-1:WIDTH];
    add_b   = ma_q;
    add_cin = 1'b0;
    if (state_q == StFin) begin
      add_a   = ~p_q[WIDTH-1:0];
      add_b   = '0;
      add_cin = 1'b1;
    end
  end

  adder_32_bit #(
    .WIDTH (WIDTH)
  ) u_add (
    .a_i    (add_a),
    .b_i    (add_b),
    .cin_i  (add_cin),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  adder_32_bit #(
    .WIDTH (WIDTH)
  ) u_neg_hi (
    .a_i    (~p_q[2*WIDTH-1:WIDTH]),
    .b_i    ('0),
    .cin_i  (add_cout),
    .sum_o  (neg_hi),
    .cout_o (unused_neg_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    ma_d    = ma_q;
    sign_d  = sign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          sign_d  = bus.is_signed & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          ma_d    = abs_a;
          p_d     = {{WIDTH{1'b0}}, abs_b};
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        if (p_q[0]) begin
          p_d = {add_cout, add_sum, p_q[WIDTH-1:1]};
        end else begin
          p_d = {1'b0, p_q[2*WIDTH-1:WIDTH], p_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntWidth'(Iter - 1)) state_d = StFin;
      end
      StFin: begin
        if (sign_q) begin
          hi_d = neg_hi;
          lo_d = add_sum;
        end else begin
          hi_d = p_q[2*WIDTH-1:WIDTH];
          lo_d = p_q[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      p_q     <= '0;
      ma_q    <= '0;
      sign_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      ma_q    <= ma_d;
      sign_q  <= sign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
